stack_ptr_unit: RTL and testbench

Stack-pointer controller for the multicycle processor datapath. It maintains an 8-bit descending stack pointer and runs PUSH and POP transactions against the single-port synchronous data memory. PUSH pre-decrements the pointer; POP post-increments it. It is the decrementing, memory-writing counterpart of the PC incrementer path. The control FSM issues one-cycle push/pop requests and waits on `busy`/`done`.

---
 rtl/stack_ptr_unit_if.sv | 34 +++
 rtl/stack_ptr_unit.sv | 115 +++++++++++
 tb/tb_stack_ptr_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/stack_ptr_unit_if.sv
// stack_ptr_unit_if
// Request/response and data-memory bus of the stack-pointer controller.
//   push, pop, data_in  : requester -> unit (push/pop sampled only in IDLE)
//   mem_rdata           : memory -> unit (valid the cycle after mem_re)
//   mem_addr, mem_wdata,
//   mem_we, mem_re      : unit -> single-port synchronous data memory
//   pop_data, sp, busy,
//   done, err           : unit -> requester status
// Modports: master = requester/memory side, slave = stack_ptr_unit.
interface stack_ptr_unit_if;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] pop_data;
  logic [7:0] sp;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output push, pop, data_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, pop_data, sp, busy, done, err
  );

  modport slave (
    input  push, pop, data_in, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, pop_data, sp, busy, done, err
  );
endinterface

// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit
// Descending 8-bit stack-pointer controller running PUSH (pre-decrement,
// memory write) and POP (memory read, post-increment) transactions against
// a single-port synchronous data memory.
// Parameters:
//   RESET_SP : pointer after reset, also the empty-stack value
//   SP_MIN   : lowest legal pointer; stack full when sp == SP_MIN
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : stack_ptr_unit_if.slave (requests, memory bus, status)
module stack_ptr_unit #(
  parameter logic [7:0] RESET_SP = 8'hFF,
  parameter logic [7:0] SP_MIN   = 8'h80
) (
  input  logic                  clock,
  input  logic                  reset,
  stack_ptr_unit_if.slave       bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PUSH_WR = 2'd1;
  localparam logic [1:0] POP_RD  = 2'd2;
  localparam logic [1:0] POP_CAP = 2'd3;

  logic [1:0] state;
  logic [7:0] sp_q;
  logic [7:0] data_q;
  logic [7:0] pop_data_q;
  logic       done_q;
  logic       err_q;

  logic       is_full;
  logic       is_empty;

  assign is_full  = (sp_q == SP_MIN);
  assign is_empty = (sp_q == RESET_SP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sp_q       <= RESET_SP;
      data_q     <= '0;
      pop_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // done/err are single-cycle pulses; only the branches below raise them
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          // push outranks pop; a simultaneous pop is dropped silently
          if (bus.push) begin
            if (is_full) begin
              err_q <= 1'b1;
            end else begin
              data_q <= bus.data_in;
              state  <= PUSH_WR;
            end
          end else if (bus.pop) begin
            if (is_empty) begin
              err_q <= 1'b1;
            end else begin
              state <= POP_RD;
            end
          end
        end
        PUSH_WR: begin
          sp_q   <= sp_q - 8'd1;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        POP_RD: begin
          state <= POP_CAP;
        end
        POP_CAP: begin
          // read data for the POP_RD address arrives this cycle
          pop_data_q <= bus.mem_rdata;
          sp_q       <= sp_q + 8'd1;
          done_q     <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = sp_q;
    bus.mem_wdata = '0;
    case (state)
      PUSH_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_q - 8'd1;
        bus.mem_wdata = data_q;
      end
      POP_RD: begin
        bus.mem_re = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sp       = sp_q;
  assign bus.pop_data = pop_data_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
module tb_stack_ptr_unit;

  logic clock;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  stack_ptr_unit_if ifc ();

  stack_ptr_unit #(
    .RESET_SP(8'hFF),
    .SP_MIN  (8'h80)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural single-port synchronous RAM
  logic [7:0] ram [0:255];
  always @(posedge clock) begin
    if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
    if (ifc.mem_re) ifc.mem_rdata <= ram[ifc.mem_addr];
  end

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] data;
    logic [7:0] sp;
    logic       busy;
    logic       done;
    logic       err;
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] pdata;
  } vec_t;

  vec_t vecs [19];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_status(input string tag, input logic [7:0] exp_sp,
                                 input logic exp_done, input logic exp_err);
    chk({tag, " sp"},   ifc.sp, exp_sp);
    chk({tag, " busy"}, {7'd0, ifc.busy}, 8'd0);
    chk({tag, " done"}, {7'd0, ifc.done}, {7'd0, exp_done});
    chk({tag, " err"},  {7'd0, ifc.err},  {7'd0, exp_err});
    chk({tag, " we"},   {7'd0, ifc.mem_we}, 8'd0);
    chk({tag, " re"},   {7'd0, ifc.mem_re}, 8'd0);
  endtask

  task automatic do_push(input logic [7:0] d);
    ifc.push = 1'b1;
    ifc.data_in = d;
    step();
    ifc.push = 1'b0;
    ifc.data_in = '0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ifc.mem_rdata = '0;
    ifc.push = 1'b0;
    ifc.pop = 1'b0;
    ifc.data_in = '0;

    //            push pop  data   sp    bsy  dne  err  we   re   addr   wdata  pdata
    vecs[0]  = '{1'b0,1'b1,8'h00,8'hFF,1'b0,1'b0,1'b1,1'b0,1'b0,8'hFF,8'h00,8'h00};
    vecs[1]  = '{1'b1,1'b1,8'hA5,8'hFF,1'b1,1'b0,1'b0,1'b1,1'b0,8'hFE,8'hA5,8'h00};
    vecs[2]  = '{1'b0,1'b1,8'h00,8'hFE,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFE,8'h00,8'h00};
    vecs[3]  = '{1'b0,1'b0,8'h00,8'hFE,1'b0,1'b0,1'b0,1'b0,1'b0,8'hFE,8'h00,8'h00};
    vecs[4]  = '{1'b0,1'b1,8'h00,8'hFE,1'b1,1'b0,1'b0,1'b0,1'b1,8'hFE,8'h00,8'h00};
    vecs[5]  = '{1'b0,1'b0,8'h00,8'hFE,1'b1,1'b0,1'b0,1'b0,1'b0,8'hFE,8'h00,8'h00};
    vecs[6]  = '{1'b0,1'b0,8'h00,8'hFF,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFF,8'h00,8'hA5};
    vecs[7]  = '{1'b1,1'b0,8'h3C,8'hFF,1'b1,1'b0,1'b0,1'b1,1'b0,8'hFE,8'h3C,8'hA5};
    vecs[8]  = '{1'b1,1'b0,8'h77,8'hFE,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFE,8'h00,8'hA5};
    vecs[9]  = '{1'b1,1'b0,8'h77,8'hFE,1'b1,1'b0,1'b0,1'b1,1'b0,8'hFD,8'h77,8'hA5};
    vecs[10] = '{1'b0,1'b0,8'h00,8'hFD,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFD,8'h00,8'hA5};
    vecs[11] = '{1'b0,1'b1,8'h00,8'hFD,1'b1,1'b0,1'b0,1'b0,1'b1,8'hFD,8'h00,8'hA5};
    vecs[12] = '{1'b0,1'b0,8'h00,8'hFD,1'b1,1'b0,1'b0,1'b0,1'b0,8'hFD,8'h00,8'hA5};
    vecs[13] = '{1'b0,1'b1,8'h00,8'hFE,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFE,8'h00,8'h77};
    vecs[14] = '{1'b0,1'b1,8'h00,8'hFE,1'b1,1'b0,1'b0,1'b0,1'b1,8'hFE,8'h00,8'h77};
    vecs[15] = '{1'b0,1'b0,8'h00,8'hFE,1'b1,1'b0,1'b0,1'b0,1'b0,8'hFE,8'h00,8'h77};
    vecs[16] = '{1'b0,1'b0,8'h00,8'hFF,1'b0,1'b1,1'b0,1'b0,1'b0,8'hFF,8'h00,8'h3C};
    vecs[17] = '{1'b0,1'b1,8'h00,8'hFF,1'b0,1'b0,1'b1,1'b0,1'b0,8'hFF,8'h00,8'h3C};
    vecs[18] = '{1'b0,1'b0,8'h00,8'hFF,1'b0,1'b0,1'b0,1'b0,1'b0,8'hFF,8'h00,8'h3C};

    // reset held two cycles with push asserted
    reset = 1'b1;
    ifc.push = 1'b1;
    ifc.data_in = 8'h5A;
    step();
    chk_idle_status("rst c1", 8'hFF, 1'b0, 1'b0);
    step();
    chk_idle_status("rst c2", 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    ifc.push = 1'b0;
    ifc.data_in = '0;
    step();
    chk_idle_status("rst after", 8'hFF, 1'b0, 1'b0);
    chk("rst pop_data", ifc.pop_data, 8'h00);

    // vector table: inputs applied in one cycle, outputs checked the next
    for (int i = 0; i < 19; i++) begin
      ifc.push    = vecs[i].push;
      ifc.pop     = vecs[i].pop;
      ifc.data_in = vecs[i].data;
      step();
      chk($sformatf("v%0d sp", i),       ifc.sp, vecs[i].sp);
      chk($sformatf("v%0d busy", i),     {7'd0, ifc.busy}, {7'd0, vecs[i].busy});
      chk($sformatf("v%0d done", i),     {7'd0, ifc.done}, {7'd0, vecs[i].done});
      chk($sformatf("v%0d err", i),      {7'd0, ifc.err},  {7'd0, vecs[i].err});
      chk($sformatf("v%0d we", i),       {7'd0, ifc.mem_we}, {7'd0, vecs[i].we});
      chk($sformatf("v%0d re", i),       {7'd0, ifc.mem_re}, {7'd0, vecs[i].re});
      chk($sformatf("v%0d addr", i),     ifc.mem_addr, vecs[i].addr);
      chk($sformatf("v%0d wdata", i),    ifc.mem_wdata, vecs[i].wdata);
      chk($sformatf("v%0d pop_data", i), ifc.pop_data, vecs[i].pdata);
    end
    ifc.push = 1'b0;
    ifc.pop = 1'b0;
    ifc.data_in = '0;

    // round trip: push 11, 22, then pop twice
    do_push(8'h11);
    chk("rt push1 done", {7'd0, ifc.done}, 8'd1);
    do_push(8'h22);
    chk("rt push2 sp", ifc.sp, 8'hFD);
    for (int k = 0; k < 2; k++) begin
      ifc.pop = 1'b1;
      step();
      ifc.pop = 1'b0;
      chk($sformatf("rt pop%0d c1 re", k), {7'd0, ifc.mem_re}, 8'd1);
      step();
      chk($sformatf("rt pop%0d c2 done", k), {7'd0, ifc.done}, 8'd0);
      step();
      chk($sformatf("rt pop%0d c3 done", k), {7'd0, ifc.done}, 8'd1);
      chk($sformatf("rt pop%0d data", k), ifc.pop_data, (k == 0) ? 8'h22 : 8'h11);
    end
    chk("rt final sp", ifc.sp, 8'hFF);

    // fill to SP_MIN, then one more push must be rejected
    for (int n = 0; n < 127; n++) do_push(n[7:0]);
    chk("ovf sp at min", ifc.sp, 8'h80);
    ifc.push = 1'b1;
    ifc.data_in = 8'hEE;
    step();
    ifc.push = 1'b0;
    chk_idle_status("ovf reject", 8'h80, 1'b0, 1'b1);
    step();
    chk_idle_status("ovf after", 8'h80, 1'b0, 1'b0);

    // reset during POP_RD
    ifc.pop = 1'b1;
    step();
    ifc.pop = 1'b0;
    chk("midpop re", {7'd0, ifc.mem_re}, 8'd1);
    chk("midpop busy", {7'd0, ifc.busy}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_status("midpop rst", 8'hFF, 1'b0, 1'b0);
    chk("midpop pop_data", ifc.pop_data, 8'h00);
    step();
    chk_idle_status("midpop after", 8'hFF, 1'b0, 1'b0);
    chk("midpop after pop_data", ifc.pop_data, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
